// File: rtl/hawk_axi_rd_arb.sv
// rtl/hawk_axi_rd_arb.sv - two-requester AXI read arbiter, one burst outstanding
//
// Purpose: round-robin arbitration of two AXI read requesters (m0, m1) onto a
// single memory-side read port. One burst is in flight at a time: the winning
// AR is captured, replayed on s_ar*, and the R beats are steered back to the
// granted requester until s_rlast.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   m0_ar*/m1_ar*         requester AR channels (arready only in IDLE)
//   m0_r*/m1_r*           requester R channels (only the granted one sees rvalid/rlast)
//   s_ar*                 memory-side AR channel (captured request)
//   s_r*                  memory-side R channel
//   busy                  high whenever not IDLE
//   len_err               sticky beat-count/rlast mismatch flag

`ifndef HACD_MC_AXI4_DATA_WIDTH
`define HACD_MC_AXI4_DATA_WIDTH 256
`endif

module hawk_axi_rd_arb #(
    parameter int ADDR_W = 64,
    parameter int ID_W   = 6,
    parameter int DATA_W = `HACD_MC_AXI4_DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic [ID_W-1:0]   m0_arid,
    input  logic [7:0]        m0_arlen,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic [ID_W-1:0]   m0_rid,
    output logic              m0_rlast,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic [ID_W-1:0]   m1_arid,
    input  logic [7:0]        m1_arlen,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic [ID_W-1:0]   m1_rid,
    output logic              m1_rlast,
    output logic              s_arvalid,
    input  logic              s_arready,
    output logic [ADDR_W-1:0] s_araddr,
    output logic [ID_W-1:0]   s_arid,
    output logic [7:0]        s_arlen,
    input  logic              s_rvalid,
    output logic              s_rready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic [ID_W-1:0]   s_rid,
    input  logic              s_rlast,
    output logic              busy,
    output logic              len_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_last_grant;
    logic                r_grant;
    logic [ADDR_W-1:0]   r_addr;
    logic [ID_W-1:0]     r_id;
    logic [7:0]          r_len;
    logic [8:0]          r_cnt;
    logic                r_len_err;

    logic                w_idle;
    logic                w_addr_ph;
    logic                w_data_ph;
    logic                w_win;
    logic                w_accept;
    logic                w_rd_hs;
    logic [8:0]          w_beat;
    logic [8:0]          w_exp_beats;
    logic                w_len_bad;

    // Phase decodes are qualified with rst_n so every output is quiet while
    // reset is held, even in the cycle before the state register clears.
    assign w_idle    = rst_n && (r_state == S_IDLE);
    assign w_addr_ph = rst_n && (r_state == S_ADDR);
    assign w_data_ph = rst_n && (r_state == S_DATA);

    // Tie goes to the requester that did not win last time.
    assign w_win    = (m0_arvalid && m1_arvalid) ? ~r_last_grant : m1_arvalid;
    assign w_accept = w_idle && (m0_arvalid || m1_arvalid);

    assign m0_arready = w_accept && !w_win;
    assign m1_arready = w_accept &&  w_win;

    assign s_arvalid = w_addr_ph;
    assign s_araddr  = r_addr;
    assign s_arid    = r_id;
    assign s_arlen   = r_len;

    assign s_rready = w_data_ph && (r_grant ? m1_rready : m0_rready);
    assign w_rd_hs  = s_rvalid && s_rready;

    assign m0_rvalid = w_data_ph && !r_grant && s_rvalid;
    assign m0_rlast  = w_data_ph && !r_grant && s_rlast;
    assign m1_rvalid = w_data_ph &&  r_grant && s_rvalid;
    assign m1_rlast  = w_data_ph &&  r_grant && s_rlast;
    assign m0_rdata  = s_rdata;
    assign m0_rresp  = s_rresp;
    assign m0_rid    = s_rid;
    assign m1_rdata  = s_rdata;
    assign m1_rresp  = s_rresp;
    assign m1_rid    = s_rid;

    assign busy    = rst_n && (r_state != S_IDLE);
    assign len_err = rst_n && r_len_err;

    // 9-bit arithmetic so arlen=255 expects 256 beats without wrapping.
    assign w_beat      = r_cnt + 9'd1;
    assign w_exp_beats = {1'b0, r_len} + 9'd1;
    // rlast early/late, or the expected final beat arrives without rlast.
    assign w_len_bad   = s_rlast ? (w_beat != w_exp_beats) : (w_beat == w_exp_beats);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_ADDR;
            S_ADDR: if (s_arready) w_next = S_DATA;
            S_DATA: if (w_rd_hs && s_rlast) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_addr       <= '0;
            r_id         <= '0;
            r_len        <= '0;
            r_cnt        <= '0;
            r_len_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_grant <= w_win;
                r_addr  <= w_win ? m1_araddr : m0_araddr;
                r_id    <= w_win ? m1_arid   : m0_arid;
                r_len   <= w_win ? m1_arlen  : m0_arlen;
            end
            if (w_addr_ph && s_arready) begin
                r_cnt <= '0;
            end
            if (w_data_ph && w_rd_hs) begin
                r_cnt <= w_beat;
                if (w_len_bad) begin
                    r_len_err <= 1'b1;
                end
                if (s_rlast) begin
                    r_last_grant <= r_grant;
                end
            end
        end
    end

endmodule

// File: tb/tb_hawk_axi_rd_arb.sv
// tb/tb_hawk_axi_rd_arb.sv - randomized self-checking bench for hawk_axi_rd_arb

module tb_hawk_axi_rd_arb;

    localparam int AW = 64;
    localparam int IW = 6;
    localparam int DW = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          m0_arvalid, m0_arready, m1_arvalid, m1_arready;
    logic [AW-1:0] m0_araddr, m1_araddr, s_araddr;
    logic [IW-1:0] m0_arid, m1_arid, s_arid;
    logic [7:0]    m0_arlen, m1_arlen, s_arlen;
    logic          m0_rvalid, m0_rready, m0_rlast, m1_rvalid, m1_rready, m1_rlast;
    logic [DW-1:0] m0_rdata, m1_rdata, s_rdata;
    logic [1:0]    m0_rresp, m1_rresp, s_rresp;
    logic [IW-1:0] m0_rid, m1_rid, s_rid;
    logic          s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
    logic          busy, len_err;

    hawk_axi_rd_arb #(.ADDR_W(AW), .ID_W(IW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
        .m0_arid(m0_arid), .m0_arlen(m0_arlen),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata),
        .m0_rresp(m0_rresp), .m0_rid(m0_rid), .m0_rlast(m0_rlast),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
        .m1_arid(m1_arid), .m1_arlen(m1_arlen),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata),
        .m1_rresp(m1_rresp), .m1_rid(m1_rid), .m1_rlast(m1_rlast),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_arid(s_arid), .s_arlen(s_arlen),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
        .s_rresp(s_rresp), .s_rid(s_rid), .s_rlast(s_rlast),
        .busy(busy), .len_err(len_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: who owns the memory port (-1 = free), whether its
    // address is still waiting for s_arready, and how many beats it received.
    int          mdl_owner = -1;
    bit          mdl_pend  = 0;
    int          mdl_last  = 1;
    int          mdl_sent  = 0;
    int          mdl_target = 1;
    bit          mdl_err   = 0;
    logic [63:0] mdl_addr  = '0;
    logic [5:0]  mdl_id    = '0;
    logic [7:0]  mdl_len   = '0;

    // Requester intents and memory behaviour knobs.
    bit          req_v[2];
    logic [63:0] req_addr[2];
    logic [5:0]  req_id[2];
    logic [7:0]  req_len[2];
    bit          rr[2];
    int          inj_next = 0;
    int          ar_hold  = 0;
    int          p_rv = 100, p_ar = 100, p_rr = 100;
    int          rr1_q[$];

    // Observations of the DUT, compared against constants per scenario.
    int          obs_beats[2];
    int          obs_grants[$];
    int          obs_arv_cycles;
    logic [5:0]  obs_rid1;

    task automatic clr_obs();
        obs_beats[0] = 0;
        obs_beats[1] = 0;
        obs_grants.delete();
        obs_arv_cycles = 0;
        obs_rid1 = '0;
    endtask

    task automatic req(input int k, input logic [63:0] a, input logic [5:0] id, input logic [7:0] len);
        req_v[k]    = 1'b1;
        req_addr[k] = a;
        req_id[k]   = id;
        req_len[k]  = len;
    endtask

    // One clock: drive inputs, check outputs against the model, advance model.
    task automatic tick();
        bit   data;
        int   w;
        logic e_rr, e_v, e_l;
        data = (mdl_owner >= 0) && !mdl_pend;

        m0_arvalid = req_v[0]; m0_araddr = req_addr[0]; m0_arid = req_id[0]; m0_arlen = req_len[0];
        m1_arvalid = req_v[1]; m1_araddr = req_addr[1]; m1_arid = req_id[1]; m1_arlen = req_len[1];
        rr[0] = ($urandom_range(0, 99) < p_rr);
        if (rr1_q.size() > 0 && data && mdl_owner == 1) rr[1] = rr1_q.pop_front() != 0;
        else rr[1] = ($urandom_range(0, 99) < p_rr);
        m0_rready = rr[0];
        m1_rready = rr[1];
        if (rst_n && mdl_owner >= 0 && mdl_pend && ar_hold > 0) begin
            s_arready = 1'b0;
            ar_hold--;
        end else begin
            s_arready = ($urandom_range(0, 99) < p_ar);
        end
        s_rvalid = ($urandom_range(0, 99) < p_rv);
        s_rdata  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        s_rresp  = 2'($urandom);
        s_rid    = data ? mdl_id : 6'($urandom);
        s_rlast  = data && (mdl_sent + 1 == mdl_target);
        #1;

        w = -1;
        if (rst_n && mdl_owner < 0) begin
            if (req_v[0] && req_v[1]) w = (mdl_last == 1) ? 0 : 1;
            else if (req_v[0])       w = 0;
            else if (req_v[1])       w = 1;
        end
        chk("m0_arready", m0_arready, w == 0);
        chk("m1_arready", m1_arready, w == 1);
        chk("s_arvalid", s_arvalid, rst_n && mdl_owner >= 0 && mdl_pend);
        if (rst_n && mdl_owner >= 0 && mdl_pend) begin
            chk("s_araddr", s_araddr, mdl_addr);
            chk("s_arid", s_arid, mdl_id);
            chk("s_arlen", s_arlen, mdl_len);
        end
        e_rr = (rst_n && data) ? rr[mdl_owner] : 1'b0;
        chk("s_rready", s_rready, e_rr);
        e_v = rst_n && data && mdl_owner == 0 && s_rvalid;
        e_l = rst_n && data && mdl_owner == 0 && s_rlast;
        chk("m0_rvalid", m0_rvalid, e_v);
        chk("m0_rlast", m0_rlast, e_l);
        if (e_v) begin
            chk("m0_rdata", m0_rdata, s_rdata);
            chk("m0_rid", m0_rid, mdl_id);
            chk("m0_rresp", m0_rresp, s_rresp);
        end
        e_v = rst_n && data && mdl_owner == 1 && s_rvalid;
        e_l = rst_n && data && mdl_owner == 1 && s_rlast;
        chk("m1_rvalid", m1_rvalid, e_v);
        chk("m1_rlast", m1_rlast, e_l);
        if (e_v) begin
            chk("m1_rdata", m1_rdata, s_rdata);
            chk("m1_rid", m1_rid, mdl_id);
            chk("m1_rresp", m1_rresp, s_rresp);
        end
        chk("busy", busy, rst_n && mdl_owner >= 0);
        chk("len_err", len_err, rst_n && mdl_err);

        if (m0_arready) obs_grants.push_back(0);
        if (m1_arready) obs_grants.push_back(1);
        if (s_arvalid) obs_arv_cycles++;
        if (m0_rvalid && m0_rready) obs_beats[0]++;
        if (m1_rvalid && m1_rready) begin
            obs_beats[1]++;
            obs_rid1 = m1_rid;
        end

        if (!rst_n) begin
            mdl_owner = -1; mdl_pend = 0; mdl_last = 1; mdl_err = 0;
            mdl_addr = '0; mdl_id = '0; mdl_len = '0;
        end else if (mdl_owner < 0) begin
            if (w >= 0) begin
                mdl_owner = w; mdl_pend = 1;
                mdl_addr = req_addr[w]; mdl_id = req_id[w]; mdl_len = req_len[w];
                req_v[w] = 1'b0;
            end
        end else if (mdl_pend) begin
            if (s_arready) begin
                mdl_pend   = 0;
                mdl_sent   = 0;
                mdl_target = (inj_next > 0) ? inj_next : int'(mdl_len) + 1;
                inj_next   = 0;
            end
        end else if (s_rvalid && rr[mdl_owner]) begin
            mdl_sent++;
            if (s_rlast) begin
                if (mdl_sent != int'(mdl_len) + 1) mdl_err = 1;
                mdl_last  = mdl_owner;
                mdl_owner = -1;
            end else if (mdl_sent == int'(mdl_len) + 1) begin
                mdl_err = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while (!(mdl_owner < 0 && !req_v[0] && !req_v[1]) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk("timeout", 1, 0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        req_v[0] = 0; req_v[1] = 0;
        req_addr[0] = '0; req_addr[1] = '0;
        req_id[0] = '0; req_id[1] = '0;
        req_len[0] = '0; req_len[1] = '0;
        clr_obs();
        @(negedge clk);
        tick();
        tick();
        chk("rst_araddr", s_araddr, 0);
        chk("rst_arlen", s_arlen, 0);

        // Tie at the first cycle out of reset: m0 first, then m1.
        req(0, 64'h1000, 6'd3, 8'd1);
        req(1, 64'h2000, 6'd9, 8'd0);
        rst_n = 1'b1;
        clr_obs();
        run_until_idle(200);
        chk("tie_grant_cnt", obs_grants.size(), 2);
        if (obs_grants.size() == 2) begin
            chk("tie_first", obs_grants[0], 0);
            chk("tie_second", obs_grants[1], 1);
        end
        chk("tie_m0_beats", obs_beats[0], 2);
        chk("tie_m1_beats", obs_beats[1], 1);

        // Memory stalls AR for three cycles.
        clr_obs();
        ar_hold = 3;
        req(0, 64'h3000, 6'd1, 8'd0);
        run_until_idle(200);
        chk("stall_arv_cycles", obs_arv_cycles, 4);
        chk("stall_m0_beats", obs_beats[0], 1);

        // m1 with ID 5 and rready toggling 1,0,1.
        clr_obs();
        rr1_q = '{1, 0, 1};
        req(1, 64'h4000, 6'd5, 8'd2);
        run_until_idle(200);
        chk("rid_m1_beats", obs_beats[1], 3);
        chk("rid_m0_beats", obs_beats[0], 0);
        chk("rid_value", obs_rid1, 5);

        // Full 256-beat burst.
        clr_obs();
        req(0, 64'h5000, 6'd2, 8'd255);
        run_until_idle(1000);
        chk("long_beats", obs_beats[0], 256);
        chk("long_len_err", len_err, 0);

        // Early rlast sets the sticky error.
        clr_obs();
        inj_next = 1;
        req(0, 64'h6000, 6'd4, 8'd1);
        run_until_idle(200);
        chk("early_len_err", len_err, 1);
        chk("early_beats", obs_beats[0], 1);
        for (int i = 0; i < 5; i++) tick();
        chk("early_sticky", len_err, 1);
        chk("early_idle", busy, 0);

        // Reset during the first data beat abandons the burst.
        req(0, 64'h7000, 6'd6, 8'd3);
        n = 0;
        while (!(mdl_owner == 0 && !mdl_pend) && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("timeout_data", 1, 0);
        rst_n = 1'b0;
        tick();
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_rvalid", m0_rvalid, 0);
        chk("rst_mid_len_err", len_err, 0);
        rst_n = 1'b1;
        clr_obs();
        req(0, 64'h8000, 6'd7, 8'd0);
        run_until_idle(200);
        chk("after_rst_grants", obs_grants.size(), 1);
        chk("after_rst_beats", obs_beats[0], 1);

        // Randomized traffic with stalls, length errors and occasional reset.
        p_rv = 70; p_ar = 60; p_rr = 70;
        for (int c = 0; c < 2000; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!req_v[k] && $urandom_range(0, 7) == 0)
                    req(k, {$urandom, $urandom}, 6'($urandom), 8'($urandom_range(0, 7)));
            end
            if (inj_next == 0 && $urandom_range(0, 15) == 0) inj_next = $urandom_range(1, 10);
            rst_n = ($urandom_range(0, 399) != 0);
            tick();
        end
        rst_n = 1'b1;
        p_rv = 100; p_ar = 100; p_rr = 100;
        run_until_idle(500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hawk_axi_rd_arb.md
HAWK_AXI_RD_ARB -- requirements
Module: hawk_axi_rd_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, AXI read address width.
REQ-002 SHALL have parameter ID_W, default 6, AXI ID width.
REQ-003 SHALL have parameter DATA_W, default `HACD_MC_AXI4_DATA_WIDTH (256), read data width.
REQ-004 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-006 SHALL have ports m0_arvalid in 1, m0_arready out 1, m0_araddr in ADDR_W, m0_arid in ID_W, m0_arlen in 8: requester 0 AR channel.
REQ-007 SHALL have ports m0_rvalid out 1, m0_rready in 1, m0_rdata out DATA_W, m0_rresp out 2, m0_rid out ID_W, m0_rlast out 1: requester 0 R channel.
REQ-008 SHALL have an identical port set prefixed m1_ for requester 1.
REQ-009 SHALL have ports s_arvalid out 1, s_arready in 1, s_araddr out ADDR_W, s_arid out ID_W, s_arlen out 8: memory-side AR channel.
REQ-010 SHALL have ports s_rvalid in 1, s_rready out 1, s_rdata in DATA_W, s_rresp in 2, s_rid in ID_W, s_rlast in 1: memory-side R channel.
REQ-011 SHALL have port busy  out  1  high whenever the state is not IDLE.
REQ-012 SHALL have port len_err  out  1  sticky beat-count/rlast mismatch flag.

Function
REQ-013 SHALL implement states IDLE, ADDR and DATA, with exactly one transaction outstanding on the memory side.
REQ-014 In IDLE, a single m*_arvalid SHALL win; if both are valid, the requester not in last_grant SHALL win (round-robin).
REQ-015 In IDLE, the winner's m*_arready SHALL be asserted combinationally in the same cycle; the winner's araddr/arid/arlen SHALL be captured and the state SHALL go to ADDR.
REQ-016 m*_arready SHALL never be asserted outside IDLE, and the loser SHALL never see arready.
REQ-017 In ADDR, s_arvalid SHALL be 1 with the captured fields held stable until s_arready; on that handshake the state SHALL go to DATA and the beat counter SHALL clear.
REQ-018 Latency: for a request accepted at cycle N with s_arready tied high, s_arvalid SHALL be high at cycle N+1 and DATA SHALL be entered at N+2.
REQ-019 In DATA, the granted requester's m*_rvalid/rdata/rresp/rid/rlast SHALL equal the s_r* inputs combinationally, and s_rready SHALL equal that requester's m*_rready.
REQ-020 The non-granted requester's m*_rvalid and m*_rlast SHALL be 0 at all times.
REQ-021 s_rready SHALL be 0 outside DATA.
REQ-022 The 9-bit beat counter SHALL increment on each s_rvalid&s_rready handshake in DATA; arlen=255 means 256 beats.
REQ-023 On a handshake with s_rlast=1, the state SHALL go to IDLE and last_grant SHALL take the granted index.
REQ-024 If s_rlast arrives on beat k != arlen+1, len_err SHALL be set and the state SHALL still return to IDLE.
REQ-025 If arlen+1 beats complete without s_rlast, len_err SHALL be set and beats SHALL keep being forwarded until s_rlast.
REQ-026 A new request SHALL be arbitrated no earlier than the cycle after the rlast handshake (IDLE entry).
REQ-027 s_arid SHALL equal the captured requester ID unmodified; IDs SHALL NOT be remapped.

Reset
REQ-028 While rst_n=0 at a clk edge: state IDLE, last_grant=1 (m0 wins first tie), counter 0, len_err 0, captured fields 0.
REQ-029 While in reset, all outputs SHALL be 0: s_arvalid, s_rready, m*_arready, m*_rvalid, m*_rlast, busy and len_err.
REQ-030 Reset asserted mid-transaction SHALL abandon the transaction, with no completion delivered to any requester.

Verification
REQ-031 Both arvalid at first cycle after reset (m0 addr 0x1000 len 1, m1 addr 0x2000 len 0) -> m0 granted first, 2 beats to m0 with rlast on beat 2, then m1 granted, 1 beat.
REQ-032 m0 only, s_arready low 3 cycles -> s_arvalid held with s_araddr stable 3 cycles; DATA entered the cycle after s_arready.
REQ-033 Grant m1, memory returns s_rid=5 and m1_rready toggles 1,0,1 -> s_rready mirrors m1_rready, m0_rvalid stays 0, m1_rid=5.
REQ-034 arlen=1, memory sends rlast on beat 1 -> len_err=1 and stays 1, state returns to IDLE.
REQ-035 arlen=255 -> 256 beats accepted with the counter not wrapping early, no len_err.
REQ-036 rst_n low during DATA beat 1 -> outputs 0 next cycle, busy=0, and a subsequent m0 request is served normally.
